// File: rtl/mem32x8_responder_if.sv
// Access bus for the 32x8 responder memory.
// Latency: n/a (signal bundle only).
// Backpressure: none; busy and err tell the requester when an access was refused.
//
// Ports (master = requester, slave = memory):
//   addr, data_in, read, write, clr      requester -> memory
//   data_out, rd_valid, busy, err,
//   wr_cnt, rd_cnt                       memory -> requester
interface mem32x8_responder_if #(
  parameter int WIDTH = 8
);
  logic [4:0]       addr;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic             write;
  logic             clr;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             busy;
  logic             err;
  logic [7:0]       wr_cnt;
  logic [7:0]       rd_cnt;

  modport master (
    output addr, data_in, read, write, clr,
    input  data_out, rd_valid, busy, err, wr_cnt, rd_cnt
  );

  modport slave (
    input  addr, data_in, read, write, clr,
    output data_out, rd_valid, busy, err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/mem32x8_responder.sv
// 32x8 flop memory answering single-cycle read/write strobes, with a clear sweep.
// Latency: a write is stored on its sampling edge; read data, rd_valid and err are registered, one cycle.
// Backpressure: none; accesses arriving during the clear sweep or colliding are dropped and flagged on err.
//
// Ports: clk, rst (async, active-high); bus (slave modport): addr, data_in, read,
//   write, clr in; data_out, rd_valid, busy, err, wr_cnt, rd_cnt out.
module mem32x8_responder #(
  parameter int               DEPTH     = 32,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  mem32x8_responder_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [4:0]       ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_out_q;
  logic             rd_valid_q;
  logic             busy_q;
  logic             err_q;
  logic [7:0]       wr_cnt_q;
  logic [7:0]       rd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= CLEAR_VAL;
    end else begin
      // Pulse outputs default low; only the branch that fires raises them.
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            // clr has priority: any access sampled alongside it is dropped.
            state  <= CLEAR;
            busy_q <= 1'b1;
            ptr    <= '0;
            err_q  <= bus.read | bus.write;
          end else if (bus.read && bus.write) begin
            err_q <= 1'b1;
          end else if (bus.write) begin
            mem[bus.addr] <= bus.data_in;
            if (wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
          end else if (bus.read) begin
            data_out_q <= mem[bus.addr];
            rd_valid_q <= 1'b1;
            if (rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
          end
        end
        CLEAR: begin
          // One word per cycle; clr is ignored here so the sweep never restarts.
          mem[ptr] <= CLEAR_VAL;
          ptr      <= ptr + 5'd1;
          err_q    <= bus.read | bus.write;
          if (ptr == 5'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.wr_cnt   = wr_cnt_q;
  assign bus.rd_cnt   = rd_cnt_q;

endmodule

// File: tb/tb_mem32x8_responder.sv
module tb_mem32x8_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem32x8_responder_if #(.WIDTH(8)) bus ();

  mem32x8_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: an array, two integer counters and a count of
  // sweep cycles remaining. The sweep is modelled as wiping the whole array
  // at once, since no access can observe the memory while it runs.
  logic [7:0] m_mem [32];
  int         m_wr, m_rd, m_clear_left;
  logic [7:0] m_dout;
  bit         m_rv, m_err;

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_wr = 0; m_rd = 0; m_clear_left = 0;
    m_dout = 8'h00; m_rv = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit rd, input bit wr, input bit cl,
                            input logic [4:0] a, input logic [7:0] d);
    m_rv = 0; m_err = 0;
    if (m_clear_left > 0) begin
      m_err = rd | wr;
      m_clear_left--;
    end else if (cl) begin
      m_err = rd | wr;
      m_clear_left = 32;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
    end else if (rd && wr) begin
      m_err = 1;
    end else if (wr) begin
      m_mem[a] = d;
      if (m_wr < 255) m_wr++;
    end else if (rd) begin
      m_dout = m_mem[a];
      m_rv = 1;
      if (m_rd < 255) m_rd++;
    end
  endtask

  // Apply one cycle of stimulus, advance the model, return 1 time unit after the edge.
  task automatic drive(input bit rd, input bit wr, input bit cl,
                       input logic [4:0] a, input logic [7:0] d);
    bus.read = rd; bus.write = wr; bus.clr = cl;
    bus.addr = a; bus.data_in = d;
    @(posedge clk);
    model_edge(rd, wr, cl, a, d);
    #1;
    bus.read = 0; bus.write = 0; bus.clr = 0;
  endtask

  task automatic test_reset();
    bus.read = 0; bus.write = 0; bus.clr = 0; bus.addr = '0; bus.data_in = '0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.data_out, bus.rd_valid, bus.busy, bus.err, bus.wr_cnt, bus.rd_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%0h rv=%0b busy=%0b err=%0b wr=%0d rd=%0d expected all zero",
               bus.data_out, bus.rd_valid, bus.busy, bus.err, bus.wr_cnt, bus.rd_cnt);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    drive(0, 1, 0, 5'd3, 8'hA5);
    drive(1, 0, 0, 5'd3, 8'h00);
    n_checks++;
    if (bus.data_out !== 8'hA5 || bus.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read: got dout=%0h rv=%0b expected dout=a5 rv=1", bus.data_out, bus.rd_valid);
    end
    n_checks++;
    if (bus.wr_cnt !== 8'd1 || bus.rd_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_counts: got wr=%0d rd=%0d expected wr=1 rd=1", bus.wr_cnt, bus.rd_cnt);
    end
    drive(0, 0, 0, 5'd0, 8'h00);
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd_valid_one_cycle: got rv=%0b dout=%0h expected rv=0 dout=a5", bus.rd_valid, bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int wr0, rd0;
    wr0 = m_wr; rd0 = m_rd;
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 5'(i), 8'(i + 1));
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 5'(i), 8'h00);
      n_checks++;
      if (bus.data_out !== 8'(i + 1) || bus.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: got dout=%0h rv=%0b expected dout=%0h rv=1",
                 i, bus.data_out, bus.rd_valid, i + 1);
      end
    end
    n_checks++;
    if (bus.wr_cnt !== 8'(wr0 + 32) || bus.rd_cnt !== 8'(rd0 + 32)) begin
      n_fail++;
      $display("FAIL b2b_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
               bus.wr_cnt, bus.rd_cnt, wr0 + 32, rd0 + 32);
    end
  endtask

  task automatic test_collision();
    logic [7:0] dout_before;
    int wr0, rd0;
    drive(0, 1, 0, 5'd7, 8'h3C);
    dout_before = bus.data_out;
    wr0 = m_wr; rd0 = m_rd;
    drive(1, 1, 0, 5'd7, 8'hFF);
    n_checks++;
    if (bus.err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== dout_before) begin
      n_fail++;
      $display("FAIL collision_err: got err=%0b rv=%0b dout=%0h expected err=1 rv=0 dout=%0h",
               bus.err, bus.rd_valid, bus.data_out, dout_before);
    end
    n_checks++;
    if (bus.wr_cnt !== 8'(wr0) || bus.rd_cnt !== 8'(rd0)) begin
      n_fail++;
      $display("FAIL collision_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
               bus.wr_cnt, bus.rd_cnt, wr0, rd0);
    end
    drive(1, 0, 0, 5'd7, 8'h00);
    n_checks++;
    if (bus.err !== 1'b0 || bus.data_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL collision_readback: got err=%0b dout=%0h expected err=0 dout=3c", bus.err, bus.data_out);
    end
  endtask

  task automatic test_clear();
    int busy_cycles, k;
    logic [7:0] dout_hold;
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 5'(i), 8'($urandom_range(1, 255)));
    dout_hold = bus.data_out;
    // clr together with a read: clr wins, the read is flagged.
    drive(1, 0, 1, 5'd5, 8'h00);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b1 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_read: got busy=%0b err=%0b rv=%0b expected busy=1 err=1 rv=0",
               bus.busy, bus.err, bus.rd_valid);
    end
    busy_cycles = 1;
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      if (k == 3) begin
        drive(1, 0, 0, 5'(k), 8'h00);
        n_checks++;
        if (bus.err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== dout_hold) begin
          n_fail++;
          $display("FAIL read_during_clear: got err=%0b rv=%0b dout=%0h expected err=1 rv=0 dout=%0h",
                   bus.err, bus.rd_valid, bus.data_out, dout_hold);
        end
      end else if (k == 10) begin
        drive(0, 0, 1, 5'd0, 8'h00);
      end else begin
        drive(0, 0, 0, 5'd0, 8'h00);
      end
      if (bus.busy === 1'b1) busy_cycles++;
      k++;
    end
    n_checks++;
    if (busy_cycles != 32 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_length: got %0d cycles busy_now=%0b expected 32 cycles busy_now=0",
               busy_cycles, bus.busy);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 5'(i), 8'h00);
      n_checks++;
      if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL cleared_word[%0d]: got dout=%0h rv=%0b expected dout=0 rv=1",
                 i, bus.data_out, bus.rd_valid);
      end
    end
  endtask

  task automatic test_random();
    int op;
    for (int c = 0; c < 300; c++) begin
      op = $urandom_range(0, 39);
      if (op < 16)      drive(0, 1, 0, 5'($urandom), 8'($urandom));
      else if (op < 32) drive(1, 0, 0, 5'($urandom), 8'h00);
      else if (op < 35) drive(1, 1, 0, 5'($urandom), 8'($urandom));
      else if (op < 36) drive(op[0], 1'b0, 1, 5'($urandom), 8'h00);
      else              drive(0, 0, 0, 5'($urandom), 8'($urandom));
      n_checks++;
      if (bus.data_out !== m_dout || bus.rd_valid !== m_rv || bus.err !== m_err ||
          bus.busy !== (m_clear_left > 0) || bus.wr_cnt !== 8'(m_wr) || bus.rd_cnt !== 8'(m_rd)) begin
        n_fail++;
        $display("FAIL random[%0d]: got dout=%0h rv=%0b err=%0b busy=%0b wr=%0d rd=%0d expected dout=%0h rv=%0b err=%0b busy=%0b wr=%0d rd=%0d",
                 c, bus.data_out, bus.rd_valid, bus.err, bus.busy, bus.wr_cnt, bus.rd_cnt,
                 m_dout, m_rv, m_err, (m_clear_left > 0), m_wr, m_rd);
      end
    end
    // Let any sweep started above finish before the next scenario.
    for (int c = 0; c < 40 && bus.busy === 1'b1; c++) drive(0, 0, 0, 5'd0, 8'h00);
  endtask

  task automatic test_saturation_and_async_reset();
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 5'($urandom), 8'($urandom_range(1, 255)));
    n_checks++;
    if (bus.wr_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL wr_cnt_saturate: got %0d expected 255", bus.wr_cnt);
    end
    drive(0, 0, 1, 5'd0, 8'h00);
    repeat (5) drive(0, 0, 0, 5'd0, 8'h00);
    #2;
    rst = 1;
    model_reset();
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.wr_cnt !== 8'd0 || bus.rd_cnt !== 8'd0 || bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%0b wr=%0d rd=%0d dout=%0h expected all zero",
               bus.busy, bus.wr_cnt, bus.rd_cnt, bus.data_out);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 5'd20, 8'h00);
    n_checks++;
    if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b1 || bus.rd_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL read_after_reset: got dout=%0h rv=%0b rd=%0d expected dout=0 rv=1 rd=1",
               bus.data_out, bus.rd_valid, bus.rd_cnt);
    end
  endtask

  task automatic test_last_addr();
    drive(0, 1, 0, 5'd31, 8'h5A);
    drive(1, 0, 0, 5'd31, 8'h00);
    n_checks++;
    if (bus.data_out !== 8'h5A || bus.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL last_addr: got dout=%0h rv=%0b expected dout=5a rv=1", bus.data_out, bus.rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_clear();
    test_random();
    test_saturation_and_async_reset();
    test_last_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
